sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single 1M x 16 async SRAM between two requesters: the CPU memory path and the video framebuffer fetch path.
- Sequences each access as a fixed-length multi-cycle SRAM cycle and returns a one-cycle acknowledge to the requester.
- Drives registered active-low SRAM control signals.
- Sits between the memory control logic / video fetch unit and the SRAM pins.

Parameters:
- WAIT_CYCLES, 2, number of cycles the SRAM is held selected per access (>=1).
- MAX_VID_STREAK, 4, consecutive video grants allowed while the CPU is waiting before the CPU is forced a turn (>=1).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- CPU_Req  in  1  CPU access request; held high with Addr/WE/WData stable until CPU_Ack
- CPU_WE  in  1  1=write, 0=read
- CPU_Addr  in  20  CPU word address
- CPU_WData  in  16  CPU write data
- CPU_RData  out  16  CPU read data, valid while CPU_Ack=1
- CPU_Ack  out  1  one-cycle completion pulse
- VID_Req  in  1  video read request; same hold rule as CPU_Req
- VID_Addr  in  20  video word address
- VID_RData  out  16  video read data, valid while VID_Ack=1
- VID_Ack  out  1  one-cycle completion pulse
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  registered active-low SRAM controls
- SRAM_ADDR  out  20  registered SRAM address
- SRAM_DQ  inout  16  SRAM data bus

Behaviour:
- Clk is the only clock. Reset is synchronous and active-low.
- Reset=0 at an edge forces:
  - state IDLE, all *_N=1, SRAM_ADDR=0, DQ high-Z;
  - CPU_Ack=VID_Ack=0, CPU_RData=VID_RData=0, vid_streak=0, wait counter=0.
- FSM: IDLE -> ACCESS -> RELEASE -> IDLE.
- IDLE:
  - Samples requests. If none, stays in IDLE.
  - Otherwise latches the grant, address, WE and write data, loads the counter with WAIT_CYCLES-1, and goes to ACCESS.
  - Outputs are all *_N=1.
- Arbitration, evaluated in IDLE:
  - Only one request present: grant it.
  - Both present: grant video unless vid_streak==MAX_VID_STREAK, in which case grant CPU.
  - A CPU grant clears vid_streak.
  - A video grant increments vid_streak (saturating at MAX_VID_STREAK) only if CPU_Req is also high; otherwise it clears vid_streak.
- ACCESS lasts exactly WAIT_CYCLES cycles:
  - CE_N=0, LB_N=0, UB_N=0, SRAM_ADDR=latched address.
  - Read: OE_N=0, WE_N=1, DQ high-Z.
  - Write (CPU only): OE_N=1, WE_N=0, DQ driven with latched data.
  - Read data is captured from DQ at the final ACCESS edge.
- RELEASE lasts 1 cycle:
  - All *_N=1, DQ high-Z.
  - The granted requester's Ack=1 with RData holding the captured word. For a write, CPU_RData is unchanged.
  - Next state is IDLE.
- Latency: a request seen in IDLE at edge k gives Ack high during cycle k+WAIT_CYCLES+1.
- Back-to-back: the minimum period between accesses is WAIT_CYCLES+2 cycles.
- Requesters are registered:
  - Each deasserts Req at the edge where it samples Ack=1.
  - A Req still high in the IDLE after RELEASE is a new request.
- Req dropped before Ack is a protocol violation. The access completes anyway and the Ack is still issued.
- Requests are ignored outside IDLE. A late-arriving request waits and is not lost while held.
- RData registers hold their value between Acks. The two Acks are never high in the same cycle.
- Reset asserted mid-ACCESS aborts the access: controls go high at that edge, no Ack is issued, and a write may be partial.

Decomposition:
- Package sram_arbiter_pkg:
  - state enum {IDLE, ACCESS, RELEASE};
  - grant enum {GNT_CPU, GNT_VID};
  - SRAM address/data width constants (20, 16).
- Reuse the existing BidirectionalTriState for SRAM_DQ. Its WriteEnable is the registered write-drive flag.
- No other sub-module.

Test Plan:
- Reset: hold Reset=0 for 3 cycles with both Reqs high -> all *_N=1, both Acks=0, DQ high-Z; first access begins the cycle after Reset=1.
- CPU write then read (WAIT_CYCLES=2): write 0xBEEF to 0x00123 -> WE_N=0 for exactly 2 cycles with SRAM_ADDR=0x00123 and DQ=0xBEEF; CPU_Ack at k+3; subsequent read returns CPU_RData=0xBEEF with CPU_Ack.
- Video-only read: VID_Req at 0x08000 with SRAM model word 0x1234 -> OE_N=0 for 2 cycles; VID_Ack one cycle with VID_RData=0x1234; CPU_Ack stays 0.
- Starvation guard (MAX_VID_STREAK=4): both Reqs held continuously -> grant order VID, VID, VID, VID, CPU, VID, ...
- Simultaneous single request with video idle: CPU_Req only, repeatedly -> a grant every 4 cycles; vid_streak stays 0.
- Reset mid-ACCESS during a CPU write -> controls high at the reset edge, no CPU_Ack; after release, a new request completes normally.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and widths for the two-port SRAM arbiter.
package sram_arbiter_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_VID
  } grant_e;

endpackage

// File: rtl/BidirectionalTriState.sv
// Generic tri-state pad driver: drives Bus from WriteData when WriteEnable, always reflects Bus on ReadData.
module BidirectionalTriState #(
  parameter int WIDTH = 16
) (
  input  logic             WriteEnable,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] ReadData,
  inout  wire  [WIDTH-1:0] Bus
);

  assign Bus      = WriteEnable ? WriteData : {WIDTH{1'bz}};
  assign ReadData = Bus;

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates CPU and video-fetch access to one async SRAM with fixed-length cycles
// and a video-streak limit so a waiting CPU is never starved.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES    = 2,
  parameter int MAX_VID_STREAK = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               CPU_Req,
  input  logic               CPU_WE,
  input  logic [SRAM_AW-1:0] CPU_Addr,
  input  logic [SRAM_DW-1:0] CPU_WData,
  output logic [SRAM_DW-1:0] CPU_RData,
  output logic               CPU_Ack,
  input  logic               VID_Req,
  input  logic [SRAM_AW-1:0] VID_Addr,
  output logic [SRAM_DW-1:0] VID_RData,
  output logic               VID_Ack,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_UB_N,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

  localparam int CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam int STREAK_W = $clog2(MAX_VID_STREAK + 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);

  state_e               state_q, state_d;
  grant_e               gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [SRAM_DW-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STREAK_W-1:0]  vid_streak_q, vid_streak_d;
  logic                 ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, bytes_n_q, bytes_n_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic                 drive_q, drive_d;
  logic                 cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;
  logic [SRAM_DW-1:0]   cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;
  logic [SRAM_DW-1:0]   dq_in;
  grant_e               gnt_sel;

  BidirectionalTriState #(.WIDTH(SRAM_DW)) u_dq (
    .WriteEnable (drive_q),
    .WriteData   (wdata_q),
    .ReadData    (dq_in),
    .Bus         (SRAM_DQ)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    vid_streak_d = vid_streak_q;
    addr_d       = addr_q;
    cpu_rdata_d  = cpu_rdata_q;
    vid_rdata_d  = vid_rdata_q;
    ce_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    bytes_n_d    = 1'b1;
    drive_d      = 1'b0;
    cpu_ack_d    = 1'b0;
    vid_ack_d    = 1'b0;
    gnt_sel      = GNT_CPU;

    if (CPU_Req && VID_Req) begin
      gnt_sel = (vid_streak_q == STREAK_MAX) ? GNT_CPU : GNT_VID;
    end else if (VID_Req) begin
      gnt_sel = GNT_VID;
    end

    case (state_q)
      IDLE: begin
        if (CPU_Req || VID_Req) begin
          gnt_d   = gnt_sel;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
          if (gnt_sel == GNT_CPU) begin
            vid_streak_d = '0;
            addr_d       = CPU_Addr;
            we_d         = CPU_WE;
            wdata_d      = CPU_WData;
          end else begin
            // Streak only counts video wins that actually made the CPU wait.
            if (!CPU_Req) begin
              vid_streak_d = '0;
            end else if (vid_streak_q != STREAK_MAX) begin
              vid_streak_d = vid_streak_q + 1'b1;
            end
            addr_d = VID_Addr;
            we_d   = 1'b0;
          end
          // Controls are registered, so the first ACCESS cycle is set up here.
          ce_n_d    = 1'b0;
          bytes_n_d = 1'b0;
          oe_n_d    = we_d;
          we_n_d    = !we_d;
          drive_d   = we_d;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
          if (gnt_q == GNT_CPU) begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = dq_in;
          end else begin
            vid_ack_d   = 1'b1;
            vid_rdata_d = dq_in;
          end
        end else begin
          cnt_d     = cnt_q - 1'b1;
          ce_n_d    = 1'b0;
          bytes_n_d = 1'b0;
          oe_n_d    = we_q;
          we_n_d    = !we_q;
          drive_d   = we_q;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_CPU;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      vid_streak_q <= '0;
      addr_q       <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      bytes_n_q    <= 1'b1;
      drive_q      <= 1'b0;
      cpu_ack_q    <= 1'b0;
      vid_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      vid_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      vid_streak_q <= vid_streak_d;
      addr_q       <= addr_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      bytes_n_q    <= bytes_n_d;
      drive_q      <= drive_d;
      cpu_ack_q    <= cpu_ack_d;
      vid_ack_q    <= vid_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_rdata_q  <= vid_rdata_d;
    end
  end

  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_LB_N = bytes_n_q;
  assign SRAM_UB_N = bytes_n_q;
  assign SRAM_ADDR = addr_q;
  assign CPU_Ack   = cpu_ack_q;
  assign VID_Ack   = vid_ack_q;
  assign CPU_RData = cpu_rdata_q;
  assign VID_RData = vid_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (WAIT_CYCLES=2, MAX_VID_STREAK=4) with a small SRAM model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, vid_req;
  logic [19:0] cpu_addr, vid_addr;
  logic [15:0] cpu_wdata, cpu_rdata, vid_rdata;
  logic        cpu_ack, vid_ack;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;

  logic [15:0] mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [15:0] pl_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(2), .MAX_VID_STREAK(4)) dut (
    .Clk(clk), .Reset(rst_n),
    .CPU_Req(cpu_req), .CPU_WE(cpu_we), .CPU_Addr(cpu_addr), .CPU_WData(cpu_wdata),
    .CPU_RData(cpu_rdata), .CPU_Ack(cpu_ack),
    .VID_Req(vid_req), .VID_Addr(vid_addr), .VID_RData(vid_rdata), .VID_Ack(vid_ack),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq)
  );

  // Async SRAM model: combinational read while selected with OE low, write latched on clock while WE low.
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[11:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!ce_n && !we_n && !lb_n && !ub_n) mem[sram_addr[11:0]] <= sram_dq;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One requester transaction from IDLE; checks pin behaviour each cycle and the ack latency.
  task automatic do_access(input bit is_cpu, input bit wr, input logic [19:0] a,
                           input logic [15:0] wd, input logic [15:0] exp_rd, input string tag);
    int lat = 0, we_lo = 0, oe_lo = 0;
    bit got = 0;
    logic [15:0] rd;
    if (is_cpu) begin
      cpu_req = 1'b1; cpu_we = wr; cpu_addr = a; cpu_wdata = wd;
    end else begin
      vid_req = 1'b1; vid_addr = a;
    end
    for (int c = 1; c <= 12 && !got; c++) begin
      tick();
      if (!we_n) begin
        we_lo++;
        check_eq({tag, "_wr_addr"}, {12'h0, sram_addr}, {12'h0, a});
        check_eq({tag, "_wr_dq"}, {16'h0, sram_dq}, {16'h0, wd});
      end
      if (!oe_n) begin
        oe_lo++;
        check_eq({tag, "_rd_addr"}, {12'h0, sram_addr}, {12'h0, a});
      end
      check_eq({tag, "_other_ack"}, {31'h0, is_cpu ? vid_ack : cpu_ack}, 32'h0);
      if (is_cpu ? cpu_ack : vid_ack) begin
        got = 1;
        lat = c;
      end
    end
    rd = is_cpu ? cpu_rdata : vid_rdata;
    cpu_req = 1'b0;
    vid_req = 1'b0;
    check_eq({tag, "_ack_seen"}, {31'h0, got}, 32'h1);
    check_eq({tag, "_latency"}, lat, 3);
    check_eq({tag, "_we_cycles"}, we_lo, wr ? 2 : 0);
    check_eq({tag, "_oe_cycles"}, oe_lo, wr ? 0 : 2);
    if (!wr) check_eq({tag, "_rdata"}, {16'h0, rd}, {16'h0, exp_rd});
    $display("txn %s cpu=%0d we=%0d addr=%05h rdata=%04h latency=%0d", tag, is_cpu, wr, a, rd, lat);
    tick();
    check_eq({tag, "_ack_one_cycle"}, {31'h0, is_cpu ? cpu_ack : vid_ack}, 32'h0);
  endtask

  initial begin
    int t_prev;
    int n_acks;
    logic [5:0] order;
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; vid_req = 1'b1;
    cpu_addr = 20'h00123; vid_addr = 20'h08000; cpu_wdata = 16'h0;
    pl_en = 1'b1; pl_addr = 12'h000; pl_data = 16'h1234;

    // Reset held for three edges with both requests high.
    for (int i = 0; i < 3; i++) tick();
    pl_en = 1'b0;
    check_eq("rst_ctrl", {27'h0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1f);
    check_eq("rst_acks", {30'h0, cpu_ack, vid_ack}, 32'h0);
    check_eq("rst_dq_hiz", {31'h0, dut.drive_q}, 32'h0);
    check_eq("rst_addr", {12'h0, sram_addr}, 32'h0);
    check_eq("rst_rdata", {cpu_rdata, vid_rdata}, 32'h0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_ce", {31'h0, ce_n}, 32'h0);
    check_eq("post_rst_vid_first", {12'h0, sram_addr}, 32'h08000);
    cpu_req = 1'b0; vid_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("post_rst_vid_rdata", {16'h0, vid_rdata}, 32'h1234);
    $display("txn reset done vid_rdata=%04h", vid_rdata);

    do_access(1'b1, 1'b1, 20'h00123, 16'hBEEF, 16'h0, "cpu_wr");
    do_access(1'b1, 1'b0, 20'h00123, 16'h0, 16'hBEEF, "cpu_rd");
    do_access(1'b0, 1'b0, 20'h08000, 16'h0, 16'h1234, "vid_rd");
    check_eq("cpu_rdata_hold", {16'h0, cpu_rdata}, 32'hBEEF);

    // Both requests held: four video grants, then a forced CPU turn.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00123;
    vid_req = 1'b1; vid_addr = 20'h08000;
    n_acks = 0; t_prev = 0; order = '0;
    for (int c = 1; c <= 40 && n_acks < 6; c++) begin
      tick();
      check_eq("starve_no_dual_ack", {31'h0, cpu_ack && vid_ack}, 32'h0);
      if (cpu_ack || vid_ack) begin
        order[n_acks] = cpu_ack;
        if (n_acks > 0) check_eq("starve_period", c - t_prev, 4);
        $display("txn starve grant %0d %s at cycle %0d", n_acks, cpu_ack ? "CPU" : "VID", c);
        t_prev = c;
        n_acks++;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    check_eq("starve_count", n_acks, 6);
    check_eq("starve_order", {26'h0, order}, 32'h10);
    for (int i = 0; i < 6; i++) tick();

    // CPU alone, request held: one grant every WAIT_CYCLES+2 cycles.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00123;
    n_acks = 0; t_prev = 0;
    for (int c = 1; c <= 30 && n_acks < 4; c++) begin
      tick();
      check_eq("cpu_only_vid_ack", {31'h0, vid_ack}, 32'h0);
      if (cpu_ack) begin
        if (n_acks > 0) check_eq("cpu_only_period", c - t_prev, 4);
        check_eq("cpu_only_rdata", {16'h0, cpu_rdata}, 32'hBEEF);
        $display("txn cpu_only grant %0d at cycle %0d", n_acks, c);
        t_prev = c;
        n_acks++;
      end
    end
    cpu_req = 1'b0;
    check_eq("cpu_only_count", n_acks, 4);
    check_eq("cpu_only_streak", {28'h0, dut.vid_streak_q}, 32'h0);
    for (int i = 0; i < 6; i++) tick();

    // Reset in the middle of a CPU write aborts it without an ack.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00200; cpu_wdata = 16'h5555;
    tick();
    check_eq("abort_we_low", {31'h0, we_n}, 32'h0);
    rst_n = 1'b0; cpu_req = 1'b0;
    tick();
    check_eq("abort_ctrl", {27'h0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1f);
    check_eq("abort_dq_hiz", {31'h0, dut.drive_q}, 32'h0);
    check_eq("abort_ack", {31'h0, cpu_ack}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("abort_no_late_ack", {30'h0, cpu_ack, vid_ack}, 32'h0);
    end
    $display("txn abort done");
    do_access(1'b1, 1'b0, 20'h00123, 16'h0, 16'hBEEF, "post_abort_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
